// File: rtl/operand_fetch_if.sv
// Fetch-side, register-file, writeback and ID/EX signals of the operand-fetch stage.
// slave is the stage itself; master is whatever drives and consumes it.
interface operand_fetch_if #(
  parameter int DW  = 32,
  parameter int PCW = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_instr;
  logic [PCW-1:0] in_pc;
  logic [4:0]     ard1;
  logic [4:0]     ard2;
  logic [DW-1:0]  dout1;
  logic [DW-1:0]  dout2;
  logic           wb_en;
  logic [4:0]     wb_addr;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [PCW-1:0] out_pc;
  logic [5:0]     out_opcode;
  logic [5:0]     out_funct;
  logic [DW-1:0]  out_rs_val;
  logic [DW-1:0]  out_rt_val;
  logic [DW-1:0]  out_imm;
  logic [4:0]     out_dest;
  logic           out_wr;
  logic           stall;

  modport slave (
    input  in_valid, in_instr, in_pc, dout1, dout2, wb_en, wb_addr, flush, out_ready,
    output in_ready, ard1, ard2, out_valid, out_pc, out_opcode, out_funct,
           out_rs_val, out_rt_val, out_imm, out_dest, out_wr, stall
  );

  modport master (
    output in_valid, in_instr, in_pc, dout1, dout2, wb_en, wb_addr, flush, out_ready,
    input  in_ready, ard1, ard2, out_valid, out_pc, out_opcode, out_funct,
           out_rs_val, out_rt_val, out_imm, out_dest, out_wr, stall
  );
endinterface

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: decodes register fields, reads the register file,
// blocks RAW/WAW hazards with a pending-write scoreboard, and registers ID/EX.
module operand_fetch #(
  parameter int DW  = 32,
  parameter int PCW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  operand_fetch_if.slave   bus
);
  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [5:0]     opcode;
    logic [5:0]     funct;
    logic [DW-1:0]  rs_val;
    logic [DW-1:0]  rt_val;
    logic [DW-1:0]  imm;
    logic [4:0]     dest;
    logic           wr;
  } idex_t;

  idex_t        idex;
  logic         out_valid;
  logic [31:0]  pending, pending_nxt;

  logic [5:0]    opcode;
  logic [4:0]    rs, rt, rd, dest;
  logic          uses_rs, uses_rt, wr;
  logic [DW-1:0] imm, sext, zext, jext;
  logic          hazard, out_free, in_ready, issue;
  logic          unused_shamt;

  assign opcode = bus.in_instr[31:26];
  assign rs     = bus.in_instr[25:21];
  assign rt     = bus.in_instr[20:16];
  assign rd     = bus.in_instr[15:11];
  assign sext   = {{(DW-16){bus.in_instr[15]}}, bus.in_instr[15:0]};
  assign zext   = {{(DW-16){1'b0}}, bus.in_instr[15:0]};
  assign jext   = {{(DW-26){1'b0}}, bus.in_instr[25:0]};
  assign unused_shamt = ^bus.in_instr[10:6];

  assign bus.ard1 = rs;
  assign bus.ard2 = rt;

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    wr      = 1'b0;
    dest    = '0;
    imm     = '0;
    case (opcode)
      6'h00: begin
        uses_rs = 1'b1; uses_rt = 1'b1; wr = 1'b1; dest = rd;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23: begin
        uses_rs = 1'b1; wr = 1'b1; dest = rt; imm = sext;
      end
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        uses_rs = 1'b1; wr = 1'b1; dest = rt; imm = zext;
      end
      6'h2B, 6'h04, 6'h05: begin
        uses_rs = 1'b1; uses_rt = 1'b1; imm = sext;
      end
      6'h02: imm = jext;
      default: ;
    endcase
    // r0 is hardwired; writing it is a no-op and must never be tracked
    if (dest == 5'd0) wr = 1'b0;
  end

  assign hazard   = (uses_rs && pending[rs]) || (uses_rt && pending[rt]) || (wr && pending[dest]);
  assign out_free = !out_valid || bus.out_ready;
  assign in_ready = !hazard && out_free && !bus.flush;
  assign issue    = bus.in_valid && in_ready;

  assign bus.in_ready = in_ready;
  assign bus.stall    = bus.in_valid && hazard;

  // Clears first so a same-edge set on the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (bus.wb_en && bus.wb_addr != 5'd0) pending_nxt[bus.wb_addr] = 1'b0;
    if (bus.flush && out_valid && idex.wr) pending_nxt[idex.dest] = 1'b0;
    if (issue && wr) pending_nxt[dest] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      idex      <= '0;
    end else begin
      pending <= pending_nxt;
      if (issue) begin
        out_valid   <= 1'b1;
        idex.pc     <= bus.in_pc;
        idex.opcode <= opcode;
        idex.funct  <= bus.in_instr[5:0];
        idex.rs_val <= bus.dout1;
        idex.rt_val <= bus.dout2;
        idex.imm    <= imm;
        idex.dest   <= dest;
        idex.wr     <= wr;
      end else if (bus.flush || bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_pc     = idex.pc;
  assign bus.out_opcode = idex.opcode;
  assign bus.out_funct  = idex.funct;
  assign bus.out_rs_val = idex.rs_val;
  assign bus.out_rt_val = idex.rt_val;
  assign bus.out_imm    = idex.imm;
  assign bus.out_dest   = idex.dest;
  assign bus.out_wr     = idex.wr;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hand-computed vectors checked with immediate assertions.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  operand_fetch_if #(.DW(32), .PCW(32)) bus ();
  operand_fetch #(.DW(32), .PCW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic wb(input logic [4:0] a);
    bus.wb_en = 1'b1; bus.wb_addr = a;
    tick();
    bus.wb_en = 1'b0; bus.wb_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    bus.dout1 = '0; bus.dout2 = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_wr", bus.out_wr, 0);
    chk("rst_out_imm", bus.out_imm, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_pending", dut.pending, 0);
    rst_n = 1'b1;
    tick();

    // addi r1,r0,5 then add r2,r3,r4
    drive(1'b1, 32'h20010005, 32'h100);
    #1;
    chk("ard1_addi", bus.ard1, 0);
    chk("ard2_addi", bus.ard2, 1);
    chk("in_ready_addi", bus.in_ready, 1);
    tick();
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_dest", bus.out_dest, 1);
    chk("addi_imm", bus.out_imm, 5);
    chk("addi_wr", bus.out_wr, 1);
    chk("addi_opcode", bus.out_opcode, 6'h08);
    chk("addi_pc", bus.out_pc, 32'h100);
    drive(1'b1, 32'h00641020, 32'h104);
    bus.dout1 = 32'd7; bus.dout2 = 32'd9;
    #1;
    chk("ard1_add", bus.ard1, 3);
    chk("ard2_add", bus.ard2, 4);
    chk("in_ready_add", bus.in_ready, 1);
    tick();
    chk("add_rs_val", bus.out_rs_val, 7);
    chk("add_rt_val", bus.out_rt_val, 9);
    chk("add_dest", bus.out_dest, 2);
    chk("add_funct", bus.out_funct, 6'h20);
    chk("pend_1_2", dut.pending, 32'h6);
    drive(1'b0, 32'h0, 32'h0);
    wb(5'd1);
    chk("drain_valid", bus.out_valid, 0);
    wb(5'd2);
    chk("pend_clear", dut.pending, 0);

    // RAW: lw r5 then add r6,r5,r5
    drive(1'b1, 32'h8C050000, 32'h200);
    tick();
    chk("lw_dest", bus.out_dest, 5);
    drive(1'b1, 32'h00A53020, 32'h204);
    #1;
    chk("raw_stall0", bus.stall, 1);
    chk("raw_ready0", bus.in_ready, 0);
    tick();
    chk("raw_bubble", bus.out_valid, 0);
    chk("raw_stall1", bus.stall, 1);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5;
    #1;
    chk("raw_stall_wbcyc", bus.stall, 1);
    chk("raw_ready_wbcyc", bus.in_ready, 0);
    tick();
    bus.wb_en = 1'b0; bus.wb_addr = '0;
    chk("raw_not_yet", bus.out_valid, 0);
    chk("raw_stall_clr", bus.stall, 0);
    chk("raw_ready_set", bus.in_ready, 1);
    tick();
    chk("raw_issue_valid", bus.out_valid, 1);
    chk("raw_issue_dest", bus.out_dest, 6);
    drive(1'b0, 32'h0, 32'h0);
    wb(5'd6);

    // immediate extension
    drive(1'b1, 32'h200AFFFF, 32'h300);
    tick();
    chk("imm_addi_sext", bus.out_imm, 32'hFFFFFFFF);
    drive(1'b1, 32'h340BFFFF, 32'h304);
    tick();
    chk("imm_ori_zext", bus.out_imm, 32'h0000FFFF);
    chk("imm_ori_dest", bus.out_dest, 11);
    drive(1'b1, 32'h0BFFFFFF, 32'h308);
    tick();
    chk("imm_j", bus.out_imm, 32'h03FFFFFF);
    chk("imm_j_wr", bus.out_wr, 0);
    drive(1'b0, 32'h0, 32'h0);
    wb(5'd10);
    wb(5'd11);
    chk("pend_after_imm", dut.pending, 0);

    // backpressure
    drive(1'b1, 32'h200C1234, 32'h400);
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h340D0055, 32'h404);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", bus.in_ready, 0);
      tick();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_pc", bus.out_pc, 32'h400);
      chk("bp_imm", bus.out_imm, 32'h1234);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    tick();
    chk("bp_next_valid", bus.out_valid, 1);
    chk("bp_next_pc", bus.out_pc, 32'h404);
    chk("bp_next_imm", bus.out_imm, 32'h55);
    drive(1'b0, 32'h0, 32'h0);
    wb(5'd12);
    wb(5'd13);

    // flush a held addi r7
    drive(1'b1, 32'h20070001, 32'h500);
    bus.out_ready = 1'b0;
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_pend7_set", dut.pending[7], 1);
    bus.flush = 1'b1;
    #1;
    chk("fl_ready", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_pend7_clr", dut.pending[7], 0);
    drive(1'b1, 32'h00E04020, 32'h504);
    #1;
    chk("fl_dep_stall", bus.stall, 0);
    tick();
    chk("fl_dep_valid", bus.out_valid, 1);
    chk("fl_dep_dest", bus.out_dest, 8);
    drive(1'b0, 32'h0, 32'h0);
    wb(5'd8);

    // r0 destination and same-edge set/clear
    drive(1'b1, 32'h00220020, 32'h600);
    tick();
    chk("r0_wr", bus.out_wr, 0);
    chk("r0_pending", dut.pending, 0);
    drive(1'b1, 32'h20090003, 32'h604);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9;
    tick();
    bus.wb_en = 1'b0; bus.wb_addr = '0;
    chk("sim_pend9", dut.pending[9], 1);
    drive(1'b1, 32'h01207020, 32'h608);
    #1;
    chk("sim_stall", bus.stall, 1);
    chk("sim_ready", bus.in_ready, 0);
    chk("sim_valid_before", bus.out_valid, 1);

    // async reset mid-stall
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", bus.stall, 0);
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_pending", dut.pending, 0);
    chk("arst_pc", bus.out_pc, 0);
    #10;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch pipeline stage that sits directly upstream of the 32x32 register file.
- Accepts instructions from fetch over a valid/ready handshake and decodes the register fields.
- Drives the register-file read addresses and captures the returned operands, sign/zero-extended immediate and destination info into an ID/EX output register.
- A 32-bit pending-write scoreboard stalls RAW/WAW hazards until writeback retires the producing write.

Parameters:
- DW, 32, datapath and register width.
- PCW, 32, program-counter width.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- In_valid  in  1  fetch has an instruction
- In_ready  out  1  stage accepts In_instr this cycle
- In_instr  in  32  instruction word
- In_pc  in  PCW  instruction address
- Ard1  out  5  register-file read address 1 (rs = In_instr[25:21])
- Ard2  out  5  register-file read address 2 (rt = In_instr[20:16])
- Dout1  in  DW  register-file data for Ard1 (combinational read)
- Dout2  in  DW  register-file data for Ard2
- WbEn  in  1  writeback writes the register file this cycle
- WbAddr  in  5  writeback destination
- Flush  in  1  kill the instruction held in the output register
- Out_valid  out  1  ID/EX register holds an instruction
- Out_ready  in  1  execute consumes the output this cycle
- Out_pc  out  PCW  captured In_pc
- Out_opcode  out  6  instr[31:26]
- Out_funct  out  6  instr[5:0]
- Out_rs_val  out  DW  captured Dout1
- Out_rt_val  out  DW  captured Dout2
- Out_imm  out  DW  extended immediate
- Out_dest  out  5  destination register
- Out_wr  out  1  instruction writes a register
- Stall  out  1  In_valid high but issue blocked by a hazard

Behaviour:
- Reset (async, Rst_n=0): Out_valid=0, all Out_* data=0, Out_wr=0, scoreboard pending[31:0]=0.
- Ard1/Ard2 are combinational from In_instr every cycle, independent of In_valid.
- Decode classes, by opcode:
  - 6'h00 R-type: uses rs and rt; dest=rd [15:11]; wr=1.
  - 6'h08–6'h0B ALU-imm, sign-extend: uses rs; dest=rt; wr=1.
  - 6'h0C–6'h0F ALU-imm, zero-extend: uses rs; dest=rt; wr=1.
  - 6'h23 lw, sign-extend: uses rs; dest=rt; wr=1.
  - 6'h2B sw, sign-extend: uses rs and rt; wr=0.
  - 6'h04/6'h05 branch, sign-extend: uses rs and rt; wr=0.
  - 6'h02 jump: uses none; Out_imm = zero-extended instr[25:0]; wr=0.
  - Any other opcode: treated as nop (uses none, wr=0, imm=0).
- Destination register 0 forces wr=0 and is never marked pending.
- Hazard = (uses rs and pending[rs]) or (uses rt and pending[rt]) or (wr and pending[dest]). Register 0 is never pending.
- out_free = !Out_valid or Out_ready.
- Issue = In_valid and !hazard and out_free; In_ready = !hazard and out_free.
- Stall = In_valid and hazard.
- Latency: one cycle. On an issue edge, every Out_* field loads from the current In_instr, In_pc, Dout1 and Dout2, and Out_valid becomes 1.
- Out_valid with Out_ready and no issue: Out_valid becomes 0 and data holds.
- Out_valid with !Out_ready: all Out_* hold stable.
- Scoreboard is evaluated at each edge:
  - WbEn with WbAddr≠0 clears pending[WbAddr].
  - Issue with wr sets pending[dest].
  - If set and clear target the same register, set wins.
- Hazard checks use only the registered pending bits. A source retired by writeback in cycle N is readable and issuable in cycle N+1, matching the register file's write-at-edge timing.
- Flush:
  - At the edge, Out_valid becomes 0.
  - If the killed entry had Out_wr=1, pending[Out_dest] is cleared, unless a same-edge issue sets that same bit.
  - Issue in the Flush cycle is suppressed (In_ready=0 while Flush=1).
  - Flush with Out_valid=0 has no effect.
- Rst_n asserted mid-stream drops the held instruction and all pending bits immediately, with no clock required.

Test Plan:
- Reset then stream: addi r1,r0,5 (0x20010005), then R-type add r2,r3,r4 with Dout1=7, Dout2=9, Out_ready=1.
  - Required: Out_dest=1, Out_imm=5, Out_wr=1 on the first cycle.
  - Required: the add issues next cycle with Out_rs_val=7, Out_rt_val=9.
- RAW: issue lw r5 then add r6,r5,r5.
  - Required: Stall=1 and In_ready=0 until WbEn=1, WbAddr=5.
  - Required: add issues exactly one cycle after the WbEn edge.
- Immediate extension: addi imm 0xFFFF → Out_imm=0xFFFFFFFF; ori imm 0xFFFF → 0x0000FFFF; j 0x3FFFFFF → 0x03FFFFFF.
- Backpressure: hold Out_ready=0 for 3 cycles with Out_valid=1.
  - Required: Out_* stable and In_ready=0 throughout.
  - Required: release gives back-to-back issue with no bubble.
- Flush: Out_valid=1 holding addi r7 (pending[7]=1), pulse Flush.
  - Required: Out_valid=0 and pending[7]=0 after the edge.
  - Required: a following add r8,r7,r0 issues without stall.
- Register 0 and simultaneity:
  - add r0,r1,r2 sets no pending bit.
  - WbEn for r9 on the same edge as issuing addi r9 leaves pending[9]=1.
  - Async reset mid-stall clears Stall and Out_valid immediately.
